// File: rtl/hash_autotest_pkg.sv
// Shared types and default geometry for the hash autotest write-back path.
package hash_autotest_pkg;
  localparam int PKG_HASH_WIDTH  = 128;
  localparam int PKG_BLOCK_BYTES = 512;
  localparam int HASH_BYTES      = PKG_HASH_WIDTH / 8;
  localparam int SLOTS           = PKG_BLOCK_BYTES / HASH_BYTES;
  localparam int BYTE_CNT_W      = $clog2(PKG_BLOCK_BYTES);
  localparam int SLOT_W          = $clog2(SLOTS) + 1;

  typedef enum logic {FILL, DRAIN} packer_state_t;
endpackage

// File: rtl/edge_detector.sv
// 1-bit rising-edge detector with synchronous reset; a level already high
// when reset is released is not reported until it has been seen low.
module edge_detector (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic rise
);
  logic q;
  logic armed;

  always_ff @(posedge clk) begin
    if (rst) begin
      q     <= 1'b0;
      armed <= 1'b0;
    end else begin
      q     <= sig;
      armed <= armed | ~sig;
    end
  end

  assign rise = sig & ~q & armed;
endmodule

// File: rtl/hash_block_packer.sv
// Packs captured digests into SD-sized blocks and streams them out one byte
// per valid/ready transfer, zero-padding blocks that are flushed early.
module hash_block_packer
  import hash_autotest_pkg::*;
#(
  parameter int HASH_WIDTH  = PKG_HASH_WIDTH,
  parameter int BLOCK_BYTES = PKG_BLOCK_BYTES
) (
  input  logic                                                 clk,
  input  logic                                                 rst,
  input  logic                                                 end_i,
  input  logic [HASH_WIDTH-1:0]                                hash_i,
  input  logic                                                 flush_i,
  output logic [7:0]                                           data_o,
  output logic                                                 valid_o,
  input  logic                                                 ready_i,
  output logic                                                 last_o,
  output logic                                                 overflow_o,
  output logic [15:0]                                          blocks_o,
  output logic [$clog2(BLOCK_BYTES/(HASH_WIDTH/8)):0]          slots_o
);
  localparam int HB = HASH_WIDTH / 8;
  localparam int NS = BLOCK_BYTES / HB;
  localparam int BW = $clog2(BLOCK_BYTES);
  localparam int SW = $clog2(NS) + 1;
  localparam int LW = $clog2(HB);
  localparam int IW = BW - LW;

  packer_state_t         state;
  logic [BW-1:0]         b;
  logic [HASH_WIDTH-1:0] mem [NS];

  logic                  capture;
  logic                  full;
  logic                  store;
  logic                  drop;
  logic [IW-1:0]         rd_slot;
  logic [LW-1:0]         rd_byte;
  logic [HASH_WIDTH-1:0] rd_word;
  logic [7:0]            rd_data;
  logic                  padded;

  edge_detector u_end_edge (
    .clk  (clk),
    .rst  (rst),
    .sig  (end_i),
    .rise (capture)
  );

  // The cycle where slots_o has just reached NS already belongs to the drain.
  assign full  = (slots_o == SW'(NS));
  assign store = capture && (state == FILL) && !full;
  assign drop  = capture && ((state == DRAIN) || full);

  assign rd_slot = b[BW-1:LW];
  assign rd_byte = b[LW-1:0];
  assign rd_word = mem[rd_slot];
  assign rd_data = rd_word[(HB-1-int'(rd_byte))*8 +: 8];
  assign padded  = (SW'(rd_slot) >= slots_o);

  assign data_o = (valid_o && !padded) ? rd_data : 8'h00;
  assign last_o = valid_o && (b == BW'(BLOCK_BYTES-1));

  always_ff @(posedge clk) begin
    if (store) mem[slots_o[IW-1:0]] <= hash_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= FILL;
      slots_o    <= '0;
      b          <= '0;
      valid_o    <= 1'b0;
      overflow_o <= 1'b0;
      blocks_o   <= '0;
    end else begin
      if (drop) overflow_o <= 1'b1;
      case (state)
        FILL: begin
          if (store) slots_o <= slots_o + SW'(1);
          if (full || (flush_i && slots_o != '0)) begin
            state   <= DRAIN;
            valid_o <= 1'b1;
            b       <= '0;
          end
        end
        DRAIN: begin
          if (ready_i) begin
            if (b == BW'(BLOCK_BYTES-1)) begin
              state    <= FILL;
              valid_o  <= 1'b0;
              slots_o  <= '0;
              b        <= '0;
              blocks_o <= blocks_o + 16'd1;
            end else begin
              b <= b + BW'(1);
            end
          end
        end
        default: state <= FILL;
      endcase
    end
  end
endmodule

// File: tb/tb_hash_block_packer.sv
// Scoreboard bench for hash_block_packer: stimulus closes blocks in a
// reference model, a separate monitor checks every transferred byte.
module tb_hash_block_packer;
  import hash_autotest_pkg::*;

  localparam int HW = 128;
  localparam int BB = 512;
  localparam int HB = 16;
  localparam int NS = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          end_i;
  logic [HW-1:0] hash_i;
  logic          flush_i;
  logic [7:0]    data_o;
  logic          valid_o;
  logic          ready_i;
  logic          last_o;
  logic          overflow_o;
  logic [15:0]   blocks_o;
  logic [5:0]    slots_o;

  always #5 clk = ~clk;

  hash_block_packer dut (
    .clk        (clk),
    .rst        (rst),
    .end_i      (end_i),
    .hash_i     (hash_i),
    .flush_i    (flush_i),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .last_o     (last_o),
    .overflow_o (overflow_o),
    .blocks_o   (blocks_o),
    .slots_o    (slots_o)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [8:0]    exp_q[$];   // {last, byte}
  logic [HW-1:0] blk[$];     // digests held in the model's open block
  int            exp_blocks = 0;
  logic          exp_ovf    = 1'b0;
  int            bytes_seen = 0;
  int            ready_mode = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [HW-1:0] rand_hash();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // A closed block is every held digest MSB byte first, then zeros to BB bytes.
  function automatic void close_block();
    logic [HW-1:0] w;
    logic [7:0]    by;
    int            s;
    for (int k = 0; k < BB; k++) begin
      s = k / HB;
      if (s < blk.size()) begin
        w  = blk[s];
        by = w[HW-1-8*(k%HB) -: 8];
      end else begin
        by = 8'h00;
      end
      exp_q.push_back({(k == BB-1), by});
    end
    blk.delete();
    exp_blocks++;
  endfunction

  // Monitor: sampled on the falling edge, away from the active edge.
  initial begin
    logic       pv;
    logic       pr;
    logic [7:0] pd;
    logic [8:0] e;
    pv = 1'b0; pr = 1'b0; pd = 8'h00;
    forever begin
      @(negedge clk);
      if (rst) begin
        pv = 1'b0;
      end else begin
        if (pv && !pr) begin
          check("hold_valid", valid_o, 1'b1);
          check("hold_data", data_o, pd);
        end
        if (valid_o && ready_i) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_byte: got %0h expected no transfer", data_o);
          end else begin
            e = exp_q.pop_front();
            check($sformatf("data[%0d]", bytes_seen % BB), data_o, e[7:0]);
            check($sformatf("last[%0d]", bytes_seen % BB), last_o, e[8]);
          end
          bytes_seen++;
        end
        pv = valid_o; pr = ready_i; pd = data_o;
      end
    end
  end

  initial begin
    int phase;
    phase = 0;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0: ready_i = 1'b1;
        1: begin ready_i = (phase == 0 || phase == 3); phase = (phase + 1) % 4; end
        default: ready_i = 1'($urandom_range(0, 1));
      endcase
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_digest(input logic [HW-1:0] h, input bit dropped);
    hash_i = h; end_i = 1'b1;
    tick();
    end_i = 1'b0;
    if (dropped) exp_ovf = 1'b1;
    else begin
      blk.push_back(h);
      if (blk.size() == NS) close_block();
    end
    tick();
  endtask

  task automatic do_flush();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    if (blk.size() > 0) close_block();
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || valid_o) && n < 6000) begin tick(); n++; end
    check({name, "_drain_timeout"}, (n < 6000), 1'b1);
    check({name, "_blocks"}, blocks_o, 16'(exp_blocks));
    check({name, "_overflow"}, overflow_o, exp_ovf);
    check({name, "_slots_after"}, slots_o, 6'd0);
  endtask

  task automatic wait_bytes(input int target);
    int n;
    n = 0;
    while (bytes_seen < target && n < 3000) begin tick(); n++; end
    check("wait_bytes_timeout", (n < 3000), 1'b1);
  endtask

  task automatic do_reset();
    rst = 1'b1; end_i = 1'b0; flush_i = 1'b0;
    exp_q.delete(); blk.delete();
    exp_blocks = 0; exp_ovf = 1'b0;
    tick();
    check("rst_valid", valid_o, 1'b0);
    check("rst_slots", slots_o, 6'd0);
    check("rst_blocks", blocks_o, 16'd0);
    check("rst_overflow", overflow_o, 1'b0);
    check("rst_last", last_o, 1'b0);
    check("rst_data", data_o, 8'h00);
    rst = 1'b0;
    tick();
  endtask

  initial begin
    int            n;
    int            base;
    int            k;
    logic [HW-1:0] h;
    rst = 1'b1; end_i = 1'b0; flush_i = 1'b0; hash_i = '0; ready_i = 1'b1;
    tick();
    do_reset();

    // Full block with a latency and duration check on the final digest.
    ready_mode = 0;
    for (int i = 0; i < NS - 1; i++) send_digest({16{i[7:0]}}, 1'b0);
    h = {16{8'd31}};
    hash_i = h; end_i = 1'b1;
    tick();
    end_i = 1'b0;
    blk.push_back(h); close_block();
    check("latency_not_yet", valid_o, 1'b0);
    tick();
    check("latency_valid", valid_o, 1'b1);
    n = 0;
    while (valid_o && n < 600) begin n++; tick(); end
    check("full_block_cycles", n, 512);
    wait_drain("full");

    // Flush with nothing held is ignored.
    do_flush();
    tick(); tick();
    check("empty_flush_ignored", valid_o, 1'b0);

    // Byte order and zero padding.
    send_digest(128'h00112233_44556677_8899AABB_CCDDEEFF, 1'b0);
    check("order_slots", slots_o, 6'd1);
    do_flush();
    wait_drain("order");

    // Backpressure: fixed pattern, then random ready with a random partial block.
    ready_mode = 1;
    for (int i = 0; i < NS; i++) send_digest(rand_hash(), 1'b0);
    wait_drain("bp_pattern");
    ready_mode = 2;
    k = $urandom_range(1, NS - 1);
    for (int i = 0; i < k; i++) send_digest(rand_hash(), 1'b0);
    check("bp_rand_slots", slots_o, 6'(k));
    do_flush();
    wait_drain("bp_random");

    // Overflow: digest arriving mid-drain is dropped.
    ready_mode = 0;
    base = bytes_seen;
    for (int i = 0; i < NS; i++) send_digest(rand_hash(), 1'b0);
    wait_bytes(base + 100);
    send_digest(rand_hash(), 1'b1);
    check("overflow_set", overflow_o, 1'b1);
    wait_drain("overflow");
    ready_mode = 2;
    for (int i = 0; i < NS; i++) send_digest(rand_hash(), 1'b0);
    wait_drain("after_overflow");

    // Level end_i gives one capture.
    ready_mode = 0;
    h = rand_hash();
    hash_i = h; end_i = 1'b1;
    for (int i = 0; i < 50; i++) tick();
    end_i = 1'b0;
    tick();
    check("level_one_capture", slots_o, 6'd1);
    blk.push_back(h);
    do_flush();
    wait_drain("level");

    // Reset mid-drain, then a clean block.
    base = bytes_seen;
    for (int i = 0; i < NS; i++) send_digest(rand_hash(), 1'b0);
    wait_bytes(base + 200);
    do_reset();
    ready_mode = 2;
    for (int i = 0; i < NS; i++) send_digest(rand_hash(), 1'b0);
    wait_drain("after_reset");

    // Capture and flush on the same cycle: 3 held first, then random counts.
    ready_mode = 0;
    for (int t = 0; t < 3; t++) begin
      k = (t == 0) ? 3 : $urandom_range(1, NS - 2);
      for (int i = 0; i < k; i++) send_digest(rand_hash(), 1'b0);
      h = rand_hash();
      hash_i = h; end_i = 1'b1; flush_i = 1'b1;
      tick();
      end_i = 1'b0; flush_i = 1'b0;
      blk.push_back(h);
      close_block();
      tick();
      wait_drain("capture_flush");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
